peri_pwm_fader: RTL



---
 rtl/peri_pwm_fader.sv | 97 +++++++++
 1 files changed

// File: rtl/peri_pwm_fader.sv
// Multi-channel Wishbone PWM peripheral with a shared fade engine.
// Duties are latched at period end so pwm_o never changes mid-period.
module peri_pwm_fader #(
  parameter int CHANNELS = 3,
  parameter int DW       = 8,
  parameter int PSW      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  input  logic                wb_stb_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] pwm_o
);

  localparam logic [DW-1:0] CNT_MAX = '1;

  logic           ctrl_en;
  logic           ctrl_fade;
  logic [PSW-1:0] prescale;
  logic [PSW-1:0] psc;
  logic [DW-1:0]  cnt;
  logic [DW-1:0]  target  [CHANNELS];
  logic [DW-1:0]  level   [CHANNELS];
  logic [DW-1:0]  applied [CHANNELS];
  logic           wr;
  logic           tick;
  logic           psc_wr;

  assign wr       = wb_stb_i & wb_we_i;
  assign tick     = (psc == prescale);
  assign psc_wr   = wr && ((wb_adr_i == 4'h1) || (wb_adr_i == 4'h2));
  assign wb_ack_o = wb_stb_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en   <= 1'b0;
      ctrl_fade <= 1'b0;
      prescale  <= '0;
      psc       <= '0;
      cnt       <= '0;
      pwm_o     <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        target[n]  <= '0;
        level[n]   <= '0;
        applied[n] <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;

      if (wr && (wb_adr_i == 4'h0)) begin
        ctrl_en   <= wb_dat_i[0];
        ctrl_fade <= wb_dat_i[1];
      end
      if (wr && (wb_adr_i == 4'h1)) prescale[7:0]     <= wb_dat_i;
      if (wr && (wb_adr_i == 4'h2)) prescale[PSW-1:8] <= wb_dat_i;

      // Restarting on any PRESCALE write keeps psc <= PRESCALE at all times.
      if (psc_wr || tick) psc <= '0;
      else                psc <= psc + 1'b1;

      for (int n = 0; n < CHANNELS; n++) begin
        if (wr && (wb_adr_i == 4'(4 + n))) target[n] <= wb_dat_i[DW-1:0];

        if (!ctrl_fade) begin
          level[n] <= target[n];
        end else if (tick) begin
          if (level[n] < target[n])      level[n] <= level[n] + 1'b1;
          else if (level[n] > target[n]) level[n] <= level[n] - 1'b1;
        end

        if (cnt == CNT_MAX) applied[n] <= level[n];
        pwm_o[n] <= ctrl_en && (cnt < applied[n]);
      end
    end
  end

  always_comb begin
    wb_dat_o = '0;
    if (wb_stb_i) begin
      case (wb_adr_i)
        4'h0:    wb_dat_o = {6'b0, ctrl_fade, ctrl_en};
        4'h1:    wb_dat_o = prescale[7:0];
        4'h2:    wb_dat_o = prescale[PSW-1:8];
        default: wb_dat_o = '0;
      endcase
      for (int n = 0; n < CHANNELS; n++) begin
        if (wb_adr_i == 4'(4 + n)) wb_dat_o = 8'(target[n]);
        if (wb_adr_i == 4'(8 + n)) wb_dat_o = 8'(level[n]);
      end
    end
  end

endmodule
